// File: rtl/intf_array_rr_arbiter.sv
// Round-robin arbiter for an interface-instance array: registered one-hot grant plus index,
// bounded hold time and a one-cycle idle gap between consecutive owners.
module intf_array_rr_arbiter #(
    parameter  int unsigned NUM_REQ  = 2,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned IDX_W    = $clog2(NUM_REQ),
    localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]         state, state_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [IDX_W-1:0]   grant_idx_d;
    logic               busy_d;
    logic               timeout_d;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_d;
    logic [IDX_W-1:0]   last, last_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;

    // Winner: first requester at or after last+1, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state;
        grant_d     = grant;
        grant_idx_d = grant_idx;
        busy_d      = busy;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt;
        last_d      = last;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_OWN;
                    grant_d     = NUM_REQ'(1) << win;
                    grant_idx_d = win;
                    last_d      = win;
                    hold_cnt_d  = CNT_W'(1);
                    busy_d      = 1'b1;
                end
            end
            S_OWN: begin
                // Voluntary release wins over a simultaneous hold-limit revoke.
                if (done[grant_idx] || !req[grant_idx]) begin
                    state_d = S_GAP;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
                    state_d   = S_GAP;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
        end else begin
            state     <= state_d;
            grant     <= grant_d;
            grant_idx <= grant_idx_d;
            busy      <= busy_d;
            timeout   <= timeout_d;
            hold_cnt  <= hold_cnt_d;
            last      <= last_d;
        end
    end

endmodule

// File: tb/tb_intf_array_rr_arbiter.sv
// Directed bench for intf_array_rr_arbiter: a 2-requester vector table plus hand sequences
// for hold-limit/done collision, asynchronous reset and 4-requester wrap-around.
module tb_intf_array_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req, done, grant;
    logic       grant_idx, busy, timeout;
    logic [3:0] req4, done4, grant4;
    logic [1:0] grant_idx4;
    logic       busy4, timeout4;

    int checks = 0;
    int errors = 0;

    intf_array_rr_arbiter #(.NUM_REQ(2), .MAX_HOLD(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .grant_idx(grant_idx), .busy(busy), .timeout(timeout)
    );

    intf_array_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .done(done4),
        .grant(grant4), .grant_idx(grant_idx4), .busy(busy4), .timeout(timeout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] done;
        logic [1:0] grant;
        logic       idx;
        logic       busy;
        logic       timeout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [1:0] r, input logic [1:0] d, input logic [1:0] g,
                                input logic i, input logic b, input logic t);
        vec_t v;
        v.req = r; v.done = d; v.grant = g; v.idx = i; v.busy = b; v.timeout = t;
        vecs.push_back(v);
    endfunction

    // Grant must stay one-hot-or-zero and agree with the index whenever asserted.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!$onehot0(grant) || (grant != 2'b00 && grant != (2'b01 << grant_idx))) begin
                errors++;
                $display("FAIL grant_invariant actual grant=%b idx=%0d required onehot0 matching idx",
                         grant, grant_idx);
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; done = '0; req4 = '0; done4 = '0;
        repeat (2) step();
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst idx", 32'(grant_idx), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // Single requester, done pulsed on the third grant cycle.
        add(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        add(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        add(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        add(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        add(2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        // Both requesting: alternation with GAP+IDLE between owners.
        add(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
        add(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
        add(2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        add(2'b11, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0);
        add(2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
        add(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        add(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        // Hold limit: 8 grant cycles, timeout pulse, then re-grant.
        for (int k = 0; k < 8; k++) add(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        add(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        add(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        add(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
            chk($sformatf("v%0d idx", i), 32'(grant_idx), 32'(vecs[i].idx));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d timeout", i), 32'(timeout), 32'(vecs[i].timeout));
        end

        // done on the final allowed hold cycle: release, no timeout pulse.
        req = 2'b01; done = 2'b00;
        step();
        chk("hd first grant", 32'(grant), 32'h1);
        repeat (7) step();
        chk("hd eighth grant", 32'(grant), 32'h1);
        done = 2'b01;
        step();
        chk("hd grant drop", 32'(grant), 32'h0);
        chk("hd no timeout", 32'(timeout), 32'h0);
        chk("hd busy", 32'(busy), 32'h0);
        done = 2'b00; req = 2'b00;
        step();
        chk("hd no late timeout", 32'(timeout), 32'h0);

        // Asynchronous reset mid-ownership, then priority restarts at requester 0.
        req = 2'b01;
        step();
        chk("ar pre grant", 32'(grant), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar grant async", 32'(grant), 32'h0);
        chk("ar busy async", 32'(busy), 32'h0);
        req = 2'b11;
        #2 rst_n = 1'b1;
        step();
        chk("ar regrant", 32'(grant), 32'h1);
        chk("ar regrant idx", 32'(grant_idx), 32'h0);
        chk("ar regrant busy", 32'(busy), 32'h1);
        req = 2'b00;
        repeat (2) step();

        // Four requesters: set last=1, then 1010 picks 3, then wraps to 1.
        req4 = 4'b0010;
        step();
        chk("w4 first grant", 32'(grant4), 32'h2);
        req4 = 4'b0000;
        repeat (2) step();
        chk("w4 idle", 32'(grant4), 32'h0);
        req4 = 4'b1010;
        step();
        chk("w4 grant3", 32'(grant4), 32'h8);
        chk("w4 idx3", 32'(grant_idx4), 32'h3);
        done4 = 4'b1000;
        step();
        chk("w4 gap", 32'(grant4), 32'h0);
        done4 = 4'b0000;
        step();
        chk("w4 idle2", 32'(grant4), 32'h0);
        chk("w4 idle idx hold", 32'(grant_idx4), 32'h3);
        step();
        chk("w4 wrap grant1", 32'(grant4), 32'h2);
        chk("w4 wrap idx1", 32'(grant_idx4), 32'h1);
        chk("w4 timeout", 32'(timeout4), 32'h0);
        req4 = 4'b0000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
